// File: rtl/fifo_burst_reader.sv
// Drain stage between sync_fifo's read port and a valid/ready consumer.
// Buffers up to two words and frames the output stream into BURST_LEN-beat bursts.
module fifo_burst_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  read_req,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  rdata_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  bursts_done
);

    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [CNT_WIDTH-1:0]  bursts_q, bursts_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;

    logic                  xfer;
    logic                  wr;
    logic                  credit_ok;
    logic                  at_last;
    logic [1:0]            eff_count;

    // Credit uses the pre-transfer count so a landing word always has a slot.
    assign credit_ok = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2;
    assign read_req  = enable & ~fifo_empty & ~flush & ~reset & credit_ok;

    assign xfer      = valid_q & out_ready;
    assign wr        = rdata_valid & inflight_q & ~flush;
    assign at_last   = (beat_q == LAST_BEAT);
    assign eff_count = count_q - {1'b0, xfer};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        inflight_d = read_req;
        head_d     = head_q;
        tail_d     = tail_q;
        beat_d     = beat_q;
        bursts_d   = bursts_q;

        if (xfer) begin
            head_d  = tail_q;
            count_d = eff_count;
            if (at_last) begin
                beat_d   = '0;
                bursts_d = bursts_q + CNT_WIDTH'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end

        // Writes land after the shift so a simultaneous pop and push keeps order.
        if (wr) begin
            if (eff_count == 2'd0) begin
                head_d = read_data;
            end else begin
                tail_d = read_data;
            end
            count_d = eff_count + 2'd1;
        end

        case (state_q)
            IDLE:    if (count_d != 2'd0) state_d = ACTIVE;
            ACTIVE:  if (xfer && at_last && count_d == 2'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d    = IDLE;
            count_d    = '0;
            inflight_d = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            beat_d     = '0;
        end

        valid_d = (count_d != 2'd0);
        last_d  = valid_d & (beat_d == LAST_BEAT);
        busy_d  = valid_d | inflight_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            beat_q     <= '0;
            bursts_q   <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            beat_q     <= beat_d;
            bursts_q   <= bursts_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = head_q;
    assign out_last    = last_q;
    assign busy        = busy_q;
    assign bursts_done = bursts_q;

endmodule
